// File: rtl/fpga_pkg.sv
// Shared definitions for the fpga primitive library (fpga_srle and friends).
package fpga_pkg;

  localparam int unsigned FPGA_SRLE_MAX_DEPTH = 64;
  localparam int unsigned FPGA_SRLE_MAX_AW    = $clog2(FPGA_SRLE_MAX_DEPTH);

  // Wide enough to hold any legal fpga_srle read address.
  typedef logic [FPGA_SRLE_MAX_AW-1:0] fpga_srle_addr_t;

  function automatic int unsigned fpga_srle_aw(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fpga_srle_fill.sv
// Saturating fill counter for fpga_srle: counts enabled shifts up to DEPTH, never wraps.
module fpga_srle_fill #(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          E_i,
  output logic [CW-1:0] count_o,
  output logic          full_o
);

  logic [CW-1:0] r_count;
  logic          r_full;

  // full is tracked alongside the count so it comes straight from a flop
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_count <= '0;
      r_full  <= 1'b0;
    end else if (E_i && !r_full) begin
      r_count <= r_count + CW'(1);
      r_full  <= (r_count == CW'(DEPTH - 1));
    end
  end

  assign count_o = r_count;
  assign full_o  = r_full;

endmodule

// File: rtl/fpga_srle.sv
// Addressable shift register with clock enable, synchronous reset and fill tracking.
// Define FPGA_SRLE_OREG_EN to register Q_o/valid_o (one extra cycle of read latency).
module fpga_srle
  import fpga_pkg::*;
#(
  parameter  int unsigned WIDTH = 1,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = fpga_srle_aw(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             E_i,
  input  logic [WIDTH-1:0] D_i,
  input  logic [AW-1:0]    A_i,
  output logic [WIDTH-1:0] Q_o,
  output logic             valid_o,
  output logic             full_o
);

  if (DEPTH > FPGA_SRLE_MAX_DEPTH || DEPTH < 2) begin : g_depth_chk
    $error("fpga_srle: DEPTH must be within 2..%0d", FPGA_SRLE_MAX_DEPTH);
  end

  logic [WIDTH-1:0] r_stage [DEPTH];
  logic [CW-1:0]    w_count;
  logic             w_full;
  fpga_srle_addr_t  w_addr;
  logic [WIDTH-1:0] w_q;
  logic             w_valid;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
    end else if (E_i) begin
      r_stage[0] <= D_i;
      for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
    end
  end

  fpga_srle_fill #(.DEPTH(DEPTH)) u_fill (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .E_i     (E_i),
    .count_o (w_count),
    .full_o  (w_full)
  );

  assign w_addr = fpga_srle_addr_t'(A_i);

  // Compare-based mux so addresses past DEPTH-1 fall through to zero, never X
  always_comb begin
    w_q     = '0;
    w_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_addr == fpga_srle_addr_t'(k)) begin
        w_q     = r_stage[k];
        w_valid = (CW'(k) < w_count);
      end
    end
  end

`ifdef FPGA_SRLE_OREG_EN
  logic [WIDTH-1:0] r_q;
  logic             r_valid;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_q     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_q     <= w_q;
      r_valid <= w_valid;
    end
  end

  assign Q_o     = r_q;
  assign valid_o = r_valid;
`else
  assign Q_o     = w_q;
  assign valid_o = w_valid;
`endif

  assign full_o = w_full;

endmodule

// File: tb/tb_fpga_srle.sv
// Self-checking bench for fpga_srle: DEPTH=16 and DEPTH=10 instances against a queue model.
module tb_fpga_srle;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] din = 8'h00;
  logic [3:0] a16 = 4'd0;
  logic [3:0] a10 = 4'd0;
  logic [7:0] q16, q10;
  logic       v16, v10, f16, f10;

  int checks   = 0;
  int failures = 0;

  // Model: newest word at the front, size = fill level
  logic [7:0] m16[$];
  logic [7:0] m10[$];

  always #5 clk = ~clk;

  fpga_srle #(.WIDTH(8), .DEPTH(16)) u_dut16 (
    .clk_i(clk), .reset_i(rst), .E_i(en), .D_i(din), .A_i(a16),
    .Q_o(q16), .valid_o(v16), .full_o(f16)
  );

  fpga_srle #(.WIDTH(8), .DEPTH(10)) u_dut10 (
    .clk_i(clk), .reset_i(rst), .E_i(en), .D_i(din), .A_i(a10),
    .Q_o(q10), .valid_o(v10), .full_o(f10)
  );

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_q(input logic [7:0] m[$], input int a);
    return (a < m.size()) ? m[a] : 8'h00;
  endfunction

  // One clock edge with the given controls, then update the model
  task automatic step(input logic r, input logic e, input logic [7:0] d);
    rst = r; en = e; din = d;
    @(posedge clk);
    #1;
    rst = 1'b0; en = 1'b0;
    if (r) begin
      m16.delete();
      m10.delete();
    end else if (e) begin
      m16.push_front(d); if (m16.size() > 16) void'(m16.pop_back());
      m10.push_front(d); if (m10.size() > 10) void'(m10.pop_back());
    end
  endtask

  // Present an address and wait for the read path (one idle edge when registered)
  task automatic settle();
`ifdef FPGA_SRLE_OREG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic chk16(input string tag, input int a);
    a16 = 4'(a);
    settle();
    cmp({tag, ".q16"}, 32'(q16), 32'(exp_q(m16, a)));
    cmp({tag, ".v16"}, 32'(v16), 32'(a < m16.size()));
    cmp({tag, ".f16"}, 32'(f16), 32'(m16.size() == 16));
  endtask

  task automatic chk10(input string tag, input int a);
    a10 = 4'(a);
    settle();
    cmp({tag, ".q10"}, 32'(q10), 32'(exp_q(m10, a)));
    cmp({tag, ".v10"}, 32'(v10), 32'(a < m10.size()));
    cmp({tag, ".f10"}, 32'(f10), 32'(m10.size() == 10));
  endtask

  initial begin
    logic [7:0] d;
    // Reset held for two cycles, then every tap reads empty
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    for (int a = 0; a < 16; a++) chk16("rst_sweep", a);
    for (int a = 0; a < 16; a++) chk10("rst_sweep", a);

    // Basic shift order and valid boundary
    step(1'b0, 1'b1, 8'h11);
    step(1'b0, 1'b1, 8'h22);
    step(1'b0, 1'b1, 8'h33);
    chk16("shift_a0", 0);
    cmp("shift_a0_lit", 32'(q16), 32'h33);
    chk16("shift_a2", 2);
    cmp("shift_a2_lit", 32'(q16), 32'h11);
    chk16("shift_a1", 1);
    chk16("shift_a3", 3);
    cmp("shift_a3_valid_lit", 32'(v16), 32'h0);

    // Enable gaps: full rises only on the 16th enabled edge; idle cycles age nothing
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'hA0 + 8'(i));
      cmp("gap_full", 32'(f16), 32'(i == 15));
      step(1'b0, 1'b0, 8'h5A);
      cmp("gap_full_idle", 32'(f16), 32'(i == 15));
    end
    chk16("gap_a15", 15);
    cmp("gap_a15_lit", 32'(q16), 32'hA0);
    step(1'b0, 1'b1, 8'hB0);
    chk16("sat_a15", 15);
    cmp("sat_a15_lit", 32'(q16), 32'hA1);
    cmp("sat_full_lit", 32'(f16), 32'h1);
    chk16("sat_a0", 0);
    chk10("sat10_a9", 9);

    // Reset together with enable after a partial fill: reset wins
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h40 + 8'(i)));
    step(1'b1, 1'b1, 8'hFF);
    for (int a = 0; a < 16; a++) chk16("midrst", a);
    step(1'b0, 1'b1, 8'h77);
    chk16("refill_a0", 0);
    chk16("refill_a1", 1);
    cmp("refill_a1_valid_lit", 32'(v16), 32'h0);

    // Non-power-of-two depth: out-of-range taps read zero, tap 9 is the oldest word
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'(8'hC0 + 8'(i)));
    chk10("np2_a12", 12);
    cmp("np2_a12_q_lit", 32'(q10), 32'h0);
    cmp("np2_a12_v_lit", 32'(v10), 32'h0);
    chk10("np2_a9", 9);
    cmp("np2_a9_lit", 32'(q10), 32'hC2);
    chk10("np2_a15", 15);

    // Randomized traffic against the model
    for (int i = 0; i < 250; i++) begin
      d = 8'($urandom);
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0), d);
      chk16("rnd", int'($urandom_range(0, 15)));
      chk10("rnd", int'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
